// File: rtl/hand_gesture_detect_if.sv
`default_nettype none
// ============================================================================
//  Module   : hand_gesture_detect_if
//  Purpose  : Bus bundle between the per-frame hand colour locator, the
//             gesture detector and the control/SPI side.
//  Signals  : frame_done              - one-cycle pulse, zones valid with it
//             blue_zone / red_zone    - winning zone per colour, 0 = no hand
//             gesture_valid           - one-cycle gesture event strobe
//             gesture_code            - {hand, direction[1:0]}
//             busy / overrun          - frame in progress / sticky overrun
//             blue_x/_y, red_x/_y     - decoded hand positions (only when
//                                       HAND_POS_OUT_EN is defined)
//  Modports : master - frame source / event sink
//             slave  - the gesture detector
//  Revision : 1.0 - initial release
// ============================================================================
interface hand_gesture_detect_if #(
    parameter int ZB = 9
`ifdef HAND_POS_OUT_EN
    ,
    parameter int XB = 5,
    parameter int YB = 4
`endif
);
    logic          frame_done;
    logic [ZB-1:0] blue_zone;
    logic [ZB-1:0] red_zone;
    logic          gesture_valid;
    logic [2:0]    gesture_code;
    logic          busy;
    logic          overrun;

`ifdef HAND_POS_OUT_EN
    logic [XB-1:0] blue_x;
    logic [XB-1:0] red_x;
    logic [YB-1:0] blue_y;
    logic [YB-1:0] red_y;

    modport master (
        output frame_done, blue_zone, red_zone,
        input  gesture_valid, gesture_code, busy, overrun,
        input  blue_x, red_x, blue_y, red_y
    );

    modport slave (
        input  frame_done, blue_zone, red_zone,
        output gesture_valid, gesture_code, busy, overrun,
        output blue_x, red_x, blue_y, red_y
    );
`else
    modport master (
        output frame_done, blue_zone, red_zone,
        input  gesture_valid, gesture_code, busy, overrun
    );

    modport slave (
        input  frame_done, blue_zone, red_zone,
        output gesture_valid, gesture_code, busy, overrun
    );
`endif
endinterface
`default_nettype wire

// File: rtl/hand_gesture_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hand_gesture_detect
//  Purpose  : Once per frame decodes the winning blue and red zone indices
//             into (x,y) zone coordinates by repeated subtraction, tracks each
//             hand across frames and emits one-cycle swipe events.
//  Ports    : pclk  - pixel clock
//             rst   - asynchronous active-high reset
//             bus   - hand_gesture_detect_if.slave (frame input, gesture
//                     output, busy, overrun)
//  Options  : HAND_POS_OUT_EN - adds registered blue/red (x,y) outputs on bus
//  Revision : 1.0 - initial release
// ============================================================================
module hand_gesture_detect #(
    parameter int NX          = 20,
    parameter int NY          = 16,
    parameter int ZONES       = NX * NY,
    parameter int ZB          = $clog2(ZONES),
    parameter int SWIPE_TH    = 4,
    parameter int WIN_FRAMES  = 6,
    parameter int COOL_FRAMES = 10
) (
    input  wire logic            pclk,
    input  wire logic            rst,
    hand_gesture_detect_if.slave bus
);

    localparam int FB = $clog2(WIN_FRAMES + 1);
    localparam int CB = $clog2(COOL_FRAMES + 1);

    localparam logic [ZB-1:0] NX_Z   = ZB'(NX);
    localparam logic [ZB:0]   TH_Z   = (ZB + 1)'(SWIPE_TH);
    localparam logic [FB-1:0] WIN_Z  = FB'(WIN_FRAMES);
    localparam logic [CB-1:0] COOL_Z = CB'(COOL_FRAMES);

    typedef enum logic [2:0] {
        C_IDLE   = 3'd0,
        C_DIV    = 3'd1,
        C_EVAL   = 3'd2,
        C_EMIT_B = 3'd3,
        C_EMIT_R = 3'd4
    } ctrl_t;

    typedef enum logic [1:0] {
        H_ARM   = 2'd0,
        H_TRACK = 2'd1,
        H_COOL  = 2'd2
    } hand_t;

    // ------------------------------------------------------------------
    // Control state. Index 0 = blue hand, index 1 = red hand.
    // rem_q ends up as x, y_q as y once DIV finishes.
    // ------------------------------------------------------------------
    ctrl_t         ctrl_q, ctrl_d;
    logic [ZB-1:0] rem_q [2];
    logic [ZB-1:0] rem_d [2];
    logic [ZB-1:0] y_q   [2];
    logic [ZB-1:0] y_d   [2];
    logic [1:0]    zero_q, zero_d;      // latched zone==0 (no hand)
    logic          pend_r_q, pend_r_d;  // red event waiting behind blue
    logic [1:0]    dir_r_q, dir_r_d;
    logic          valid_q, valid_d;
    logic [2:0]    code_q, code_d;
    logic          overrun_q, overrun_d;

    // Per-hand event results, meaningful only during EVAL
    logic [1:0]    w_ev;
    logic [3:0]    w_dir;

    always_comb begin
        ctrl_d    = ctrl_q;
        rem_d     = rem_q;
        y_d       = y_q;
        zero_d    = zero_q;
        pend_r_d  = pend_r_q;
        dir_r_d   = dir_r_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        overrun_d = overrun_q | (bus.frame_done && (ctrl_q != C_IDLE));

        case (ctrl_q)
            C_IDLE: begin
                if (bus.frame_done) begin
                    rem_d[0]  = bus.blue_zone;
                    rem_d[1]  = bus.red_zone;
                    y_d[0]    = '0;
                    y_d[1]    = '0;
                    zero_d[0] = (bus.blue_zone == '0);
                    zero_d[1] = (bus.red_zone == '0);
                    ctrl_d    = C_DIV;
                end
            end
            C_DIV: begin
                if ((rem_q[0] < NX_Z) && (rem_q[1] < NX_Z)) begin
                    ctrl_d = C_EVAL;
                end
                for (int h = 0; h < 2; h++) begin
                    if (rem_q[h] >= NX_Z) begin
                        rem_d[h] = rem_q[h] - NX_Z;
                        y_d[h]   = y_q[h] + ZB'(1);
                    end
                end
            end
            C_EVAL: begin
                // Blue always goes first; a lone red event takes blue's slot
                // so its latency matches a lone blue event.
                dir_r_d  = w_dir[3:2];
                pend_r_d = 1'b0;
                if (w_ev[0]) begin
                    valid_d  = 1'b1;
                    code_d   = {1'b0, w_dir[1:0]};
                    pend_r_d = w_ev[1];
                end else if (w_ev[1]) begin
                    valid_d = 1'b1;
                    code_d  = {1'b1, w_dir[3:2]};
                end
                ctrl_d = C_EMIT_B;
            end
            C_EMIT_B: begin
                pend_r_d = 1'b0;
                if (pend_r_q) begin
                    valid_d = 1'b1;
                    code_d  = {1'b1, dir_r_q};
                    ctrl_d  = C_EMIT_R;
                end else begin
                    ctrl_d = C_IDLE;
                end
            end
            C_EMIT_R: begin
                ctrl_d = C_IDLE;
            end
            default: begin
                ctrl_d = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= C_IDLE;
            rem_q[0]  <= '0;
            rem_q[1]  <= '0;
            y_q[0]    <= '0;
            y_q[1]    <= '0;
            zero_q    <= '0;
            pend_r_q  <= 1'b0;
            dir_r_q   <= '0;
            valid_q   <= 1'b0;
            code_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            rem_q     <= rem_d;
            y_q       <= y_d;
            zero_q    <= zero_d;
            pend_r_q  <= pend_r_d;
            dir_r_q   <= dir_r_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Hand trackers, one per colour, stepped once per EVAL cycle.
    // ------------------------------------------------------------------
    for (genvar h = 0; h < 2; h++) begin : g_hand
        hand_t                hst_q, hst_d;
        logic [ZB-1:0]        ax_q, ax_d;
        logic [ZB-1:0]        ay_q, ay_d;
        logic [FB-1:0]        frm_q, frm_d;
        logic [CB-1:0]        cool_q, cool_d;
        logic                 ev;
        logic [1:0]           dir;
        logic                 w_present;
        logic signed [ZB:0]   w_dx, w_dy;
        logic [ZB:0]          w_adx, w_ady;

        assign w_present = ~zero_q[h];
        assign w_dx      = $signed({1'b0, rem_q[h]}) - $signed({1'b0, ax_q});
        assign w_dy      = $signed({1'b0, y_q[h]})   - $signed({1'b0, ay_q});
        assign w_adx     = w_dx[ZB] ? $unsigned(-w_dx) : $unsigned(w_dx);
        assign w_ady     = w_dy[ZB] ? $unsigned(-w_dy) : $unsigned(w_dy);

        always_comb begin
            hst_d  = hst_q;
            ax_d   = ax_q;
            ay_d   = ay_q;
            frm_d  = frm_q;
            cool_d = cool_q;
            ev     = 1'b0;
            dir    = 2'd0;
            if (ctrl_q == C_EVAL) begin
                case (hst_q)
                    H_ARM: begin
                        if (w_present) begin
                            ax_d  = rem_q[h];
                            ay_d  = y_q[h];
                            frm_d = '0;
                            hst_d = H_TRACK;
                        end
                    end
                    H_TRACK: begin
                        if (!w_present) begin
                            hst_d = H_ARM;
                        end else begin
                            frm_d = frm_q + FB'(1);
                            // Horizontal wins ties between |dx| and |dy|
                            if ((w_adx >= TH_Z) && (w_adx >= w_ady)) begin
                                ev  = 1'b1;
                                dir = w_dx[ZB] ? 2'd0 : 2'd1;
                            end else if (w_ady >= TH_Z) begin
                                ev  = 1'b1;
                                dir = w_dy[ZB] ? 2'd2 : 2'd3;
                            end
                            if (ev) begin
                                cool_d = COOL_Z;
                                hst_d  = H_COOL;
                            end else if (frm_d == WIN_Z) begin
                                // Too slow to be a swipe: restart from here
                                ax_d  = rem_q[h];
                                ay_d  = y_q[h];
                                frm_d = '0;
                            end
                        end
                    end
                    H_COOL: begin
                        cool_d = cool_q - CB'(1);
                        if (cool_d == '0) begin
                            if (w_present) begin
                                ax_d  = rem_q[h];
                                ay_d  = y_q[h];
                                frm_d = '0;
                                hst_d = H_TRACK;
                            end else begin
                                hst_d = H_ARM;
                            end
                        end
                    end
                    default: begin
                        hst_d = H_ARM;
                    end
                endcase
            end
        end

        always_ff @(posedge pclk or posedge rst) begin
            if (rst) begin
                hst_q  <= H_ARM;
                ax_q   <= '0;
                ay_q   <= '0;
                frm_q  <= '0;
                cool_q <= '0;
            end else begin
                hst_q  <= hst_d;
                ax_q   <= ax_d;
                ay_q   <= ay_d;
                frm_q  <= frm_d;
                cool_q <= cool_d;
            end
        end

        assign w_ev[h]          = ev;
        assign w_dir[2*h +: 2]  = dir;
    end

`ifdef HAND_POS_OUT_EN
    localparam int XB = $clog2(NX);
    localparam int YB = $clog2(NY);

    logic [XB-1:0] bx_q, rx_q;
    logic [YB-1:0] by_q, ry_q;

    // Zone 0 decodes to (0,0) naturally, so no special case is needed
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            bx_q <= '0;
            by_q <= '0;
            rx_q <= '0;
            ry_q <= '0;
        end else if (ctrl_q == C_EVAL) begin
            bx_q <= rem_q[0][XB-1:0];
            by_q <= y_q[0][YB-1:0];
            rx_q <= rem_q[1][XB-1:0];
            ry_q <= y_q[1][YB-1:0];
        end
    end

    assign bus.blue_x = bx_q;
    assign bus.blue_y = by_q;
    assign bus.red_x  = rx_q;
    assign bus.red_y  = ry_q;
`endif

    assign bus.gesture_valid = valid_q;
    assign bus.gesture_code  = code_q;
    assign bus.busy          = (ctrl_q != C_IDLE);
    assign bus.overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_hand_gesture_detect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hand_gesture_detect
//  Purpose  : Self-checking bench for hand_gesture_detect. Frames are driven
//             from directed sequences and random hand walks; a reference
//             model predicts each gesture event and its cycle, and a monitor
//             compares every strobe against the predicted queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hand_gesture_detect;

    localparam int NX = 20;
    localparam int NY = 16;
    localparam int ZB = 9;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    always #5 pclk = ~pclk;

`ifdef HAND_POS_OUT_EN
    hand_gesture_detect_if #(.ZB(ZB), .XB(5), .YB(4)) bus ();
`else
    hand_gesture_detect_if #(.ZB(ZB)) bus ();
`endif

    hand_gesture_detect #(.NX(NX), .NY(NY)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [2:0] code;
    } exp_t;

    exp_t exq[$];

    // ---------------- reference model (spec-level rules) ----------------
    int m_mode [2];  // 0 armed, 1 tracking, 2 cooling
    int m_ax   [2];
    int m_ay   [2];
    int m_fr   [2];
    int m_cool [2];

    task automatic model_reset();
        for (int h = 0; h < 2; h++) begin
            m_mode[h] = 0; m_ax[h] = 0; m_ay[h] = 0; m_fr[h] = 0; m_cool[h] = 0;
        end
    endtask

    task automatic model_hand(input int h, input int z, output bit ev, output int dir);
        int x, y, dx, dy, adx, ady;
        x = z % NX;
        y = z / NX;
        ev = 0;
        dir = 0;
        if (m_mode[h] == 0) begin
            if (z != 0) begin
                m_ax[h] = x; m_ay[h] = y; m_fr[h] = 0; m_mode[h] = 1;
            end
        end else if (m_mode[h] == 1) begin
            if (z == 0) begin
                m_mode[h] = 0;
            end else begin
                m_fr[h]++;
                dx = x - m_ax[h];
                dy = y - m_ay[h];
                adx = (dx < 0) ? -dx : dx;
                ady = (dy < 0) ? -dy : dy;
                if (adx >= 4 && adx >= ady) begin
                    ev = 1; dir = (dx < 0) ? 0 : 1;
                end else if (ady >= 4) begin
                    ev = 1; dir = (dy < 0) ? 2 : 3;
                end
                if (ev) begin
                    m_cool[h] = 10; m_mode[h] = 2;
                end else if (m_fr[h] == 6) begin
                    m_ax[h] = x; m_ay[h] = y; m_fr[h] = 0;
                end
            end
        end else begin
            m_cool[h]--;
            if (m_cool[h] == 0) begin
                if (z != 0) begin
                    m_ax[h] = x; m_ay[h] = y; m_fr[h] = 0; m_mode[h] = 1;
                end else begin
                    m_mode[h] = 0;
                end
            end
        end
    endtask

    // Predict the events of one frame whose frame_done is high in cycle fc
    task automatic model_frame(input int b, input int r, input int fc);
        bit   evb, evr;
        int   db, dr, lat;
        exp_t e;
        model_hand(0, b, evb, db);
        model_hand(1, r, evr, dr);
        lat = (((b / NX) > (r / NX)) ? (b / NX) : (r / NX)) + 3;
        if (evb) begin
            e.at = fc + lat; e.code = {1'b0, 2'(db)}; exq.push_back(e);
        end
        if (evr) begin
            e.at = fc + lat + (evb ? 1 : 0); e.code = {1'b1, 2'(dr)}; exq.push_back(e);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge pclk) begin
        if (!rst && bus.gesture_valid) begin
            if (exq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got code %0d at cycle %0d, required no event",
                         bus.gesture_code, cyc);
            end else begin
                exp_t e;
                e = exq.pop_front();
                check("event_cycle", cyc, e.at);
                check("event_code", int'(bus.gesture_code), int'(e.code));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 200) begin
            @(posedge pclk); #1;
            k++;
        end
        if (k >= 200) check("busy_timeout", 1, 0);
    endtask

    task automatic do_frame(input int b, input int r);
        wait_idle();
        @(posedge pclk); #1;
        model_frame(b, r, cyc);
        bus.frame_done = 1'b1;
        bus.blue_zone  = ZB'(b);
        bus.red_zone   = ZB'(r);
        @(posedge pclk); #1;
        bus.frame_done = 1'b0;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) do_frame(0, 0);
    endtask

    int bxp, byp, rxp, ryp;

    function automatic int walk(input int v, input int lim);
        int n;
        n = v + $urandom_range(4) - 2;
        if (n < 0) n = 0;
        if (n > lim - 1) n = lim - 1;
        return n;
    endfunction

    initial begin
        bus.frame_done = 1'b0;
        bus.blue_zone  = '0;
        bus.red_zone   = '0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_valid",   int'(bus.gesture_valid), 0);
        check("rst_code",    int'(bus.gesture_code), 0);
        check("rst_busy",    int'(bus.busy), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        rst = 1'b0;
        repeat (2) @(posedge pclk);
        #1;

        // Blue right swipe, then cooldown and a left swipe from re-anchor 55
        for (int z = 41; z <= 45; z++) do_frame(z, 0);
        for (int z = 46; z <= 55; z++) do_frame(z, 0);
        for (int z = 54; z >= 51; z--) do_frame(z, 0);
        idle_frames(12);

        // Red downward swipe, y=5 on the firing frame
        for (int i = 0; i < 5; i++) do_frame(0, 25 + 20 * i);
        idle_frames(12);

        // Both hands fire in the same frame
        for (int i = 0; i < 5; i++) do_frame(41 + i, 205 - i);
        idle_frames(12);

        // Slow drift re-anchors; a missing hand disarms
        do_frame(41, 0); do_frame(41, 0); do_frame(42, 0);
        do_frame(43, 0); do_frame(43, 0); do_frame(44, 0);
        for (int i = 0; i < 6; i++) do_frame(44, 0);
        idle_frames(2);
        do_frame(41, 0); do_frame(42, 0); do_frame(0, 0);
        do_frame(44, 0); do_frame(45, 0);
        idle_frames(2);
        check("overrun_clear", int'(bus.overrun), 0);

        // frame_done while in DIV: ignored but flagged
        do_frame(61, 0);
        bus.frame_done = 1'b1;
        bus.blue_zone  = ZB'(7);
        bus.red_zone   = ZB'(7);
        @(posedge pclk); #1;
        bus.frame_done = 1'b0;
        for (int z = 62; z <= 65; z++) do_frame(z, 0);
        wait_idle();
        check("overrun_set", int'(bus.overrun), 1);

        // Reset in the middle of a long DIV: nothing survives
        idle_frames(12);
        do_frame(244, 0);
        wait_idle();
        @(posedge pclk); #1;
        bus.frame_done = 1'b1;
        bus.blue_zone  = ZB'(300);
        bus.red_zone   = ZB'(0);
        @(posedge pclk); #1;
        bus.frame_done = 1'b0;
        @(posedge pclk); #1;
        rst = 1'b1;
        model_reset();
        @(negedge pclk);
        check("rstmid_busy",    int'(bus.busy), 0);
        check("rstmid_valid",   int'(bus.gesture_valid), 0);
        check("rstmid_code",    int'(bus.gesture_code), 0);
        check("rstmid_overrun", int'(bus.overrun), 0);
        @(posedge pclk); #1;
        rst = 1'b0;
        repeat (30) @(posedge pclk);
        #1;
        check("rstmid_busy_after", int'(bus.busy), 0);

        // Random hand walks with occasional disappearance
        bxp = 5; byp = 5; rxp = 10; ryp = 8;
        for (int f = 0; f < 300; f++) begin
            int b, r;
            bxp = walk(bxp, NX); byp = walk(byp, NY);
            rxp = walk(rxp, NX); ryp = walk(ryp, NY);
            b = ($urandom_range(5) == 0) ? 0 : byp * NX + bxp;
            r = ($urandom_range(5) == 0) ? 0 : ryp * NX + rxp;
            do_frame(b, r);
            repeat ($urandom_range(3)) @(posedge pclk);
            #1;
        end

        wait_idle();
        repeat (10) @(posedge pclk);
        #1;
        check("pending_events_left", exq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
